// File: rtl/serv_mem_pkg.sv
// Shared encodings and lane-mask helpers for the parametrised serial load/store path.
package serv_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {IDLE, BUS1, BUS2, LOAD, OUT} state_e;

  // Byte enables over a two-word window; size 3 behaves as a word.
  function automatic logic [7:0] mask_for(input logic [1:0] size, input logic [1:0] lsb);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << lsb;
  endfunction

  function automatic logic [2:0] bytes_for(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/serv_mem_ext.sv
// Aligns the 64-bit read window to the access offset, then truncates and extends.
module serv_mem_ext
  import serv_mem_pkg::*;
(
  input  logic [31:0] rdt0_i,
  input  logic [31:0] rdt1_i,
  input  logic [1:0]  lsb_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] dat_o
);

  logic [31:0] raw;
  assign raw = 32'({rdt1_i, rdt0_i} >> {lsb_i, 3'b000});

  always_comb begin
    case (size_i)
      SZ_BYTE: dat_o = {{24{signed_i & raw[7]}}, raw[7:0]};
      SZ_HALF: dat_o = {{16{signed_i & raw[15]}}, raw[15:0]};
      default: dat_o = raw;
    endcase
  end

endmodule

// File: rtl/serv_mem_ser.sv
// Bit-serial load/store data path: serial store data in, Wishbone access(es),
// sign/zero-extended load data serially out, W bits per beat.
module serv_mem_ser
  import serv_mem_pkg::*;
#(
  parameter int W                = 1,
  parameter bit SPLIT_MISALIGNED = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [W-1:0]  i_rs2,
  output logic [W-1:0]  o_rd,
  input  logic          i_req,
  input  logic          i_we,
  input  logic          i_signed,
  input  logic [1:0]    i_size,
  input  logic [31:0]   i_addr,
  output logic          o_misalign,
  output logic          o_done,
  output logic [31:0]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack
);

  localparam int BEATS = 32 / W;
  localparam int CW    = $clog2(BEATS);

  state_e        state_q, state_d;
  logic [31:0]   sreg_q;
  logic [CW-1:0] cnt_q;
  logic [29:0]   adr_q;
  logic [1:0]    lsb_q, size_q;
  logic          signed_q, we_q, cross_q;
  logic [31:0]   rdt0_q, rdt1_q;
  logic          done_q, done_d, mis_q, mis_d;

  logic          req_mis, req_cross, in_bus, in_bus2;
  logic [7:0]    mask8;
  logic [63:0]   dat64;
  logic [29:0]   wadr;
  logic [31:0]   ext_dat;

  assign req_mis   = ((i_size == SZ_HALF) & i_addr[0]) |
                     ((i_size != SZ_BYTE) & (i_size != SZ_HALF) & (|i_addr[1:0]));
  assign req_cross = ({1'b0, i_addr[1:0]} + bytes_for(i_size)) > 3'd4;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: if (i_req) begin
        if (req_mis && !SPLIT_MISALIGNED) mis_d = 1'b1;
        else                              state_d = BUS1;
      end
      BUS1: if (i_wb_ack) begin
        if (cross_q)   state_d = BUS2;
        else if (we_q) begin state_d = IDLE; done_d = 1'b1; end
        else           state_d = LOAD;
      end
      BUS2: if (i_wb_ack) begin
        if (we_q) begin state_d = IDLE; done_d = 1'b1; end
        else      state_d = LOAD;
      end
      LOAD: begin state_d = OUT; done_d = 1'b1; end
      OUT:  if (i_en && (cnt_q == CW'(BEATS - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      adr_q    <= '0;
      lsb_q    <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      cross_q  <= 1'b0;
      rdt0_q   <= '0;
      rdt1_q   <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      case (state_q)
        IDLE: begin
          if (i_en) sreg_q <= {i_rs2, sreg_q[31:W]};
          if (i_req) begin
            adr_q    <= i_addr[31:2];
            lsb_q    <= i_addr[1:0];
            size_q   <= i_size;
            we_q     <= i_we;
            signed_q <= i_signed;
            cross_q  <= SPLIT_MISALIGNED && req_cross;
            rdt1_q   <= '0;
          end
        end
        BUS1: if (i_wb_ack) rdt0_q <= i_wb_rdt;
        BUS2: if (i_wb_ack) rdt1_q <= i_wb_rdt;
        LOAD: begin
          sreg_q <= ext_dat;
          cnt_q  <= '0;
        end
        OUT: if (i_en) begin
          sreg_q <= sreg_q >> W;
          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Second beat of a split access addresses the next word, wrapping at 2^32.
  assign in_bus  = (state_q == BUS1) || (state_q == BUS2);
  assign in_bus2 = (state_q == BUS2);
  assign mask8   = mask_for(size_q, lsb_q);
  assign dat64   = {32'b0, sreg_q} << {lsb_q, 3'b000};
  assign wadr    = adr_q + {29'b0, in_bus2};

  assign o_wb_cyc   = in_bus;
  assign o_wb_we    = in_bus & we_q;
  assign o_wb_adr   = in_bus ? {wadr, 2'b00} : '0;
  assign o_wb_sel   = !in_bus ? 4'h0 : (in_bus2 ? mask8[7:4] : mask8[3:0]);
  assign o_wb_dat   = !in_bus ? 32'h0 : (in_bus2 ? dat64[63:32] : dat64[31:0]);
  assign o_done     = done_q;
  assign o_misalign = mis_q;
  assign o_rd       = (state_q == OUT) ? sreg_q[W-1:0] : '0;

  serv_mem_ext u_ext (
    .rdt0_i   (rdt0_q),
    .rdt1_i   (rdt1_q),
    .lsb_i    (lsb_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .dat_o    (ext_dat)
  );

endmodule

// File: doc/serv_mem_ser.md
Name: serv_mem_ser

Overview:
- Parametrised successor to the SERV bit-serial load/store data path.
- Shifts store data in W bits per cycle from the serial core, runs the Wishbone transaction(s) itself, then shifts sign/zero-extended load data back out W bits per cycle.
- Optionally splits word-crossing misaligned accesses into two bus cycles instead of only flagging them.
- Sits between the serial core (rs2/rd lanes, decode) and the data-side Wishbone master port.

Parameters:
- W, 1, serial lane width in bits; legal values 1, 2, 4, 8; beats per word are 32/W.
- SPLIT_MISALIGNED, 0, 1 = split word-crossing accesses into two transactions; 0 = reject them via o_misalign.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  serial beat enable (shift in when IDLE, shift out when OUT)
- i_rs2  in  W  store data lane, LSB-first
- o_rd  out  W  load data lane, LSB-first; valid only in OUT
- i_req  in  1  start pulse; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_signed  in  1  sign-extend load
- i_size  in  2  0 byte, 1 half, 2 word; 3 is treated as word
- i_addr  in  32  byte address
- o_misalign  out  1  one-cycle pulse: access rejected
- o_done  out  1  one-cycle pulse: store acked, or load data ready to shift out
- o_wb_adr  out  32  word address, bits [1:0] = 0
- o_wb_dat  out  32  store data
- o_wb_sel  out  4  byte lane enables
- o_wb_we  out  1  write strobe
- o_wb_cyc  out  1  cycle/strobe
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  acknowledge

Behaviour:
- Reset (async): state IDLE; sreg, cnt, lsb/size/signed/we regs, rdt0 = 0; all outputs 0.
- sreg is 32 bits and is shared by store and load data.
- IDLE:
  - Each i_en cycle shifts sreg <= {i_rs2, sreg[31:W]}.
  - The core supplies 32/W beats before i_req; the block does not count them.
  - On i_req, latch addr/size/we/signed.
  - Misaligned = (size half & addr[0]) | (size word & addr[1:0]!=0).
  - Crossing = byte offset + bytes > 4.
  - If misaligned and either SPLIT_MISALIGNED=0 or the access is half-aligned-but-crossing and split is disabled: pulse o_misalign next cycle, stay IDLE, no bus cycle.
  - Otherwise go to BUS1.
- Lane mapping: mask8 = {1,3,F}[size] << lsb (8-bit); dat64 = {32'b0, sreg} << 8*lsb.
- BUS1:
  - o_wb_cyc=1; adr = {addr[31:2],2'b00}; sel = mask8[3:0]; dat = dat64[31:0]; we = latched we.
  - Outputs are held stable until ack.
  - On ack, latch rdt0 = i_wb_rdt.
  - If crossing (SPLIT=1 only): next state BUS2.
  - Else, for a store: IDLE with o_done pulse. For a load: LOAD.
  - cyc deasserts the cycle after ack; there are no back-to-back strobes.
- BUS2:
  - cyc=1; adr = first adr + 4 (wraps at 2^32); sel = mask8[7:4]; dat = dat64[63:32].
  - On ack: store → IDLE with o_done; load → LOAD using rdt1 = i_wb_rdt.
- LOAD (1 cycle):
  - raw = {rdt1, rdt0} >> 8*lsb; rdt1 = 0 when there was no split.
  - Truncate to size; extend with sign bit if signed, else zero.
  - Write the result to sreg; cnt = 0; o_done pulse; go to OUT.
- OUT:
  - o_rd = sreg[W-1:0], else 0.
  - Each i_en shifts sreg right by W and increments cnt.
  - After beat 32/W-1, go to IDLE.
  - i_req is ignored in OUT.
- Boundaries and corner cases:
  - i_wb_ack with cyc=0 is ignored.
  - i_req outside IDLE is ignored.
  - Reset mid-transaction drops cyc asynchronously with no completion pulse.
  - Ack in the same cycle the state is entered is legal.
  - Zero-wait ack gives 2-cycle bus latency per transaction.

Decomposition:
- Package serv_mem_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, BUS1, BUS2, LOAD, OUT)
  - function mask_for(size, lsb) returning 8 bits
- One sub-module is natural: serv_mem_ext (combinational align/truncate/sign-extend of the 64-bit read window).

Test Plan:
- W=1, store word 0xDEADBEEF to 0x100 (32 shift beats, then i_req) → adr 0x100, sel F, dat DEADBEEF, we=1, o_done 1 cycle after ack.
- W=4, load byte signed from 0x203, rdt 0x80xxxxxx → sel 8, o_rd beats assemble 0xFFFFFF80 over 8 i_en cycles, then IDLE.
- W=2, load half unsigned from 0x302, rdt 0xBEEF0000 → sel C, result 0x0000BEEF.
- SPLIT_MISALIGNED=0, load word from 0x401 → o_misalign pulse, cyc never asserted.
- SPLIT_MISALIGNED=1, store word 0x11223344 to 0x503:
  - first cycle: adr 0x500, sel 8, dat 0x44000000
  - second cycle: adr 0x504, sel 7, dat 0x00112233
  - single o_done.
- Assert i_rst during BUS1 wait (ack withheld) → cyc=0 immediately, state IDLE, o_done never pulses; the next access completes normally.
